// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and RAM timing defaults.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int unsigned DEFAULT_RAM_LAT = 2;

endpackage

// File: rtl/ram_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Contents have no reset, so a CPU reset leaves memory intact.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Latency-modelled RAM slave: LAT BUSY cycles then one ACCESS cycle per transaction,
// restarting whenever the request changes mid-flight.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = DEFAULT_RAM_LAT,
    parameter int unsigned DEPTH = 1024
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int unsigned CW = (LAT == 0) ? 1 : $clog2(LAT + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    word_t         prev_addr_q;
    logic          prev_ren_q, prev_wen_q, prev_valid_q;

    logic  one_req, aligned, in_range, valid, err;
    logic  changed, access, mem_we;
    word_t rdata;

    assign one_req  = ramREN ^ ramWEN;
    assign aligned  = (ramaddr[1:0] == 2'b00);
    assign in_range = ({2'b00, ramaddr[31:2]} < DEPTH);
    assign valid    = one_req && aligned && in_range;
    assign err      = (ramREN || ramWEN) && !valid;

    // A request that differs from last cycle's is always its own first cycle.
    assign changed = !prev_valid_q || (ramaddr != prev_addr_q) ||
                     (ramREN != prev_ren_q) || (ramWEN != prev_wen_q);
    assign cnt_eff = changed ? '0 : cnt_q;
    assign access  = valid && !RST && (cnt_eff == CW'(LAT));
    assign mem_we  = access && ramWEN;

    always_comb begin
        cnt_d = '0;
        if (valid && !access) begin
            cnt_d = (cnt_eff < CW'(LAT)) ? cnt_eff + CW'(1) : cnt_eff;
        end
    end

    always_comb begin
        ramstate = FREE;
        if (err) begin
            ramstate = ERROR;
        end else if (valid) begin
            ramstate = access ? ACCESS : BUSY;
        end
    end

    assign ramload = (access && ramREN) ? rdata : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            prev_addr_q  <= '0;
            prev_ren_q   <= 1'b0;
            prev_wen_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            prev_valid_q <= valid;
            prev_addr_q  <= ramaddr;
            prev_ren_q   <= ramREN;
            prev_wen_q   <= ramWEN;
        end
    end

    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (ramaddr[AW+1:2]),
        .wdata (ramstore),
        .raddr (ramaddr[AW+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench: per-cycle vector table on a LAT=2 instance, hand sequence on a LAT=0 instance.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      ren, wen;
    word_t     addr, data, load;
    ramstate_t st;
    logic      ren0, wen0;
    word_t     addr0, data0, load0;
    ramstate_t st0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic      rst;
        logic      ren;
        logic      wen;
        word_t     addr;
        word_t     data;
        ramstate_t st;
        word_t     load;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ram_responder #(.LAT(2), .DEPTH(1024)) u_dut (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ren),
        .ramWEN   (wen),
        .ramaddr  (addr),
        .ramstore (data),
        .ramload  (load),
        .ramstate (st)
    );

    ram_responder #(.LAT(0), .DEPTH(1024)) u_dut0 (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ren0),
        .ramWEN   (wen0),
        .ramaddr  (addr0),
        .ramstore (data0),
        .ramload  (load0),
        .ramstate (st0)
    );

    task automatic add(input logic r, input logic rn, input logic wn, input word_t a,
                       input word_t d, input ramstate_t s, input word_t l);
        vec_t v;
        v.rst = r; v.ren = rn; v.wen = wn; v.addr = a; v.data = d; v.st = s; v.load = l;
        vecs.push_back(v);
    endtask

    // Held transaction with LAT=2: two BUSY cycles then ACCESS returning l.
    task automatic add_txn(input logic rn, input logic wn, input word_t a, input word_t d,
                           input word_t l);
        add(0, rn, wn, a, d, BUSY, 0);
        add(0, rn, wn, a, d, BUSY, 0);
        add(0, rn, wn, a, d, ACCESS, l);
    endtask

    task automatic check0(input string name, input ramstate_t es, input word_t el);
        @(negedge clk);
        total++;
        if (st0 !== es || load0 !== el) begin
            bad++;
            $display("FAIL lat0 %s: state=%0d load=%h, want state=%0d load=%h",
                     name, st0, load0, es, el);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ren = 0; wen = 0; addr = 0; data = 0;
        ren0 = 0; wen0 = 0; addr0 = 0; data0 = 0;

        add(1, 0, 0, 32'h0, 32'h0, FREE, 0);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);
        // Write then read back the same word
        add_txn(0, 1, 32'h40, 32'hDEADBEEF, 0);
        add_txn(1, 0, 32'h40, 32'h0, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);
        // Illegal requests
        add(0, 1, 1, 32'h40, 32'hBAD0BAD0, ERROR, 0);
        add(0, 1, 1, 32'h40, 32'hBAD0BAD0, ERROR, 0);
        add(0, 1, 1, 32'h40, 32'hBAD0BAD0, ERROR, 0);
        add(0, 1, 0, 32'h1000, 32'h0, ERROR, 0);
        add(0, 1, 0, 32'h42, 32'h0, ERROR, 0);
        add_txn(1, 0, 32'h40, 32'h0, 32'hDEADBEEF);
        // Top word of the array
        add_txn(0, 1, 32'hFFC, 32'hCAFEF00D, 0);
        add_txn(1, 0, 32'hFFC, 32'h0, 32'hCAFEF00D);
        add_txn(0, 1, 32'h44, 32'h11111111, 0);
        add_txn(0, 1, 32'h48, 32'hA5A5A5A5, 0);
        // Address change mid-BUSY restarts the count
        add(0, 1, 0, 32'h40, 32'h0, BUSY, 0);
        add_txn(1, 0, 32'h44, 32'h0, 32'h11111111);
        // Aborted write must not commit
        add(0, 0, 1, 32'h48, 32'h1, BUSY, 0);
        add(0, 0, 1, 32'h48, 32'h1, BUSY, 0);
        add_txn(0, 1, 32'h4C, 32'h2, 0);
        add_txn(1, 0, 32'h48, 32'h0, 32'hA5A5A5A5);
        add_txn(1, 0, 32'h4C, 32'h0, 32'h2);
        // Read turning into write mid-BUSY restarts the count
        add(0, 1, 0, 32'h44, 32'h0, BUSY, 0);
        add_txn(0, 1, 32'h44, 32'h22222222, 0);
        add_txn(1, 0, 32'h44, 32'h0, 32'h22222222);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);
        // Held read: back-to-back transactions
        for (int k = 0; k < 3; k++) add_txn(1, 0, 32'h40, 32'h0, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);
        // Reset mid-write: storage kept, held request restarts with full latency
        add_txn(0, 1, 32'h80, 32'h0BADF00D, 0);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);
        add(0, 0, 1, 32'h80, 32'h12345678, BUSY, 0);
        add(1, 0, 1, 32'h80, 32'h12345678, BUSY, 0);
        add_txn(1, 0, 32'h80, 32'h0, 32'h0BADF00D);
        add(0, 0, 1, 32'h80, 32'h12345678, BUSY, 0);
        add(1, 0, 1, 32'h80, 32'h12345678, BUSY, 0);
        add_txn(0, 1, 32'h80, 32'h12345678, 0);
        add_txn(1, 0, 32'h80, 32'h0, 32'h12345678);
        add(0, 0, 0, 32'h0, 32'h0, FREE, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; ren = vecs[i].ren; wen = vecs[i].wen;
            addr = vecs[i].addr; data = vecs[i].data;
            @(negedge clk);
            total++;
            if (st !== vecs[i].st || load !== vecs[i].load) begin
                bad++;
                $display("FAIL vec %0d: state=%0d load=%h, want state=%0d load=%h",
                         i, st, load, vecs[i].st, vecs[i].load);
            end
            @(posedge clk);
            #1;
        end

        rst = 0; ren = 0; wen = 0; addr = 0; data = 0;
        // Zero-latency instance: ACCESS in the first cycle of every request
        wen0 = 1; addr0 = 32'h0; data0 = 32'h600DCAFE;
        check0("write", ACCESS, 0);
        wen0 = 0; ren0 = 1; data0 = 0;
        check0("read", ACCESS, 32'h600DCAFE);
        check0("read again", ACCESS, 32'h600DCAFE);
        addr0 = 32'h2;
        check0("misaligned", ERROR, 0);
        ren0 = 0; addr0 = 0;
        check0("idle", FREE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter: LAT, 2, BUSY cycles before ACCESS per transaction (0..15).
REQ-002 SHALL have parameter: DEPTH, 1024, storage depth in 32-bit words (power of two).
REQ-003 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: ramREN  input  1  read request.
REQ-006 SHALL have port: ramWEN  input  1  write request.
REQ-007 SHALL have port: ramaddr  input  32  byte address (word_t).
REQ-008 SHALL have port: ramstore  input  32  write data (word_t).
REQ-009 SHALL have port: ramload  output  32  read data (word_t).
REQ-010 SHALL have port: ramstate  output  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-011 SHALL treat the request as valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0 and ramaddr[31:2] < DEPTH.
REQ-012 SHALL drive ramstate=ERROR combinationally when ramREN&&ramWEN, when the address is misaligned, or when it is out of range; no storage change; latency counter cleared.
REQ-013 SHALL drive ramstate=FREE when ramREN==ramWEN==0; counter held at 0.
REQ-014 SHALL, for a valid request held stable, drive BUSY for LAT consecutive cycles, then ACCESS for exactly one cycle (the LAT+1th cycle).
REQ-015 SHALL, with LAT=0, drive ACCESS in the first cycle a valid request is present.
REQ-016 SHALL drive ramload=mem[ramaddr[31:2]] during a read ACCESS cycle, 0 in every other cycle; combinational read permitted.
REQ-017 SHALL commit ramstore to mem[ramaddr[31:2]] at the rising edge ending a write ACCESS cycle, and at no other time.
REQ-018 SHALL, when the request is still valid after ACCESS, start a new transaction immediately (BUSY next cycle if LAT>0, ACCESS again if LAT=0).
REQ-019 SHALL abort and restart the count, with no write, if ramaddr, ramREN or ramWEN changes during BUSY; the changed request counts as its first cycle.
REQ-020 SHALL use a counter of $clog2(LAT+1) bits minimum, saturating at LAT, never wrapping.
REQ-021 SHALL produce read-after-write data: a read ACCESS following a write ACCESS to the same word returns the new value.

Reset
REQ-022 SHALL, while RST is high, force counter=0, ramstate=FREE (if no request) and ramload=0, and block all writes.
REQ-023 SHALL leave storage contents unchanged by reset.
REQ-024 SHALL, after RST deasserts mid-transaction, restart any held request with full LAT latency.

Structure
REQ-025 SHALL take word_t and ramstate_t from cpu_types_pkg; no new package types.
REQ-026 SHALL place a DEFAULT_RAM_LAT constant in cpu_types_pkg as the LAT default source.
REQ-027 SHALL isolate storage in one sub-module ram_array (DEPTH x 32, one synchronous write port, one asynchronous read port).

Verification (LAT=2, DEPTH=1024 unless stated)
REQ-028 SHALL cover: ramWEN, addr 0x40, data 0xDEADBEEF held -> BUSY,BUSY,ACCESS; then ramREN addr 0x40 -> ACCESS on 3rd cycle with ramload=0xDEADBEEF.
REQ-029 SHALL cover: ramREN=ramWEN=1, addr 0x40 -> ERROR every cycle; mem[0x10] unchanged; addr 0x1000 or 0x42 with ramREN -> ERROR.
REQ-030 SHALL cover: ramREN addr 0x40 for 1 cycle, then addr 0x44 -> BUSY,BUSY,BUSY,ACCESS overall; ACCESS returns mem[0x11].
REQ-031 SHALL cover: ramREN held 9 cycles -> ACCESS in cycles 3, 6, 9 only; ramload=0 in all non-ACCESS cycles.
REQ-032 SHALL cover: ramWEN addr 0x80 data 0x12345678, RST pulsed in cycle 2 -> mem[0x20] unchanged; after release ACCESS 3 cycles later and write commits.
REQ-033 SHALL cover: LAT=0 instance, ramREN addr 0x0 -> ACCESS in the first cycle, ramload=mem[0] the same cycle.
